host_gpio_port: RTL and testbench
=================================

# host_gpio_port

Parametrised Avalon-MM general-purpose I/O port for the host Qsys system, replacing single-bit output-only PIO instances. Provides per-bit direction control, synchronised input sampling, edge capture with maskable interrupt, and optional atomic set/clear of output bits. Sits on the host Avalon bus between the Nios master and cartridge/board control signals.

## Interface
- WIDTH, 8: number of I/O bits, 1..32.
- RESET_VALUE, 0: reset value of the output data register (low WIDTH bits used).
- RESET_DIR, 0: reset value of the direction register (1 = output).
- EDGE_TYPE, 0: edge capture mode; 0 rising, 1 falling, 2 any.
- SYNC_STAGES, 2: input synchroniser depth, 2..4.

- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- address  in  3  register word select.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- readdata  out  32  read data, zero wait state.
- in_port  in  WIDTH  asynchronous pin inputs.
- out_port  out  WIDTH  output data register.
- oe  out  WIDTH  per-bit output enable (= direction register).
- irq  out  1  level interrupt, active high.

## Operation
- Write strobe: chipselect && !write_n, sampled on rising clk. Read has no side effects.
- Register map (word addresses):
  - 0 DATA: write loads out_data[WIDTH-1:0]. Read returns per bit: dir=1 → out_data, dir=0 → synchronised input.
  - 1 DIR: R/W direction; 1 = output.
  - 2 IRQ_MASK: R/W interrupt enable per bit.
  - 3 EDGE_CAP: read captured edges; write 1 clears bit, 0 no effect.
  - 4 OUTSET: write 1 sets out_data bit (config-dependent, see below).
  - 5 OUTCLR: write 1 clears out_data bit (config-dependent).
  - 6, 7: reserved; read 0, writes ignored.
- readdata bits [31:WIDTH] always 0; writedata bits [31:WIDTH] ignored.
- Synchroniser: in_port passes SYNC_STAGES flops → sync; one further flop → sync_d.
- Edge event per bit: rising = sync & ~sync_d; falling = ~sync & sync_d; any = sync ^ sync_d. Detection on all bits regardless of direction.
- EDGE_CAP bit sets on clock following an edge event; sticky until cleared.
- Simultaneous edge event and W1C on the same bit: set wins (bit stays 1).
- irq = |(EDGE_CAP & IRQ_MASK), combinational from registers; no extra latency.
- Reset: out_data = RESET_VALUE, DIR = RESET_DIR, IRQ_MASK = 0, EDGE_CAP = 0, all sync flops = 0, irq = 0. sync/sync_d reset to 0, so an input held high out of reset produces a rising event SYNC_STAGES clocks after reset release (documented, not suppressed).
- Reset asserted mid-operation clears all state immediately (asynchronous).

## Timing
- readdata: combinational from address and registers, valid same cycle (read latency 0).
- Register writes visible on out_port/oe/readdata the cycle after the write edge.
- Input latency: in_port change setup before edge E0 appears in sync after E0+(SYNC_STAGES-1); EDGE_CAP and irq assert after edge E0+SYNC_STAGES (SYNC_STAGES+1 edges total).
- DATA read of an input bit reflects in_port after SYNC_STAGES edges.
- Pulses shorter than one clk period may be missed; no guarantee.

## Configuration
- Macro HOST_GPIO_SETCLR_EN.
- Defined: OUTSET/OUTCLR active. Same-cycle priority irrelevant (one address per cycle). Reads of addresses 4/5 return current out_data.
- Undefined: addresses 4/5 behave as reserved (read 0, writes ignored); no set/clear logic synthesised.

## Test plan
- Reset with RESET_VALUE=8'hA5, RESET_DIR=8'h0F → out_port=A5, oe=0F, irq=0, read addr 2/3 = 0.
- DIR=FF, write DATA=3C → out_port=3C next cycle; read addr 0 = 0000003C.
- EDGE_TYPE=0, IRQ_MASK=01, raise in_port[0] → EDGE_CAP=01 and irq=1 exactly SYNC_STAGES+1 edges later; write EDGE_CAP=01 → irq=0 next cycle.
- Edge event on bit 2 in the same cycle as W1C of bit 2 → EDGE_CAP[2] remains 1.
- EDGE_TYPE=2, toggle in_port[7] 1→0 with IRQ_MASK=00 → EDGE_CAP=80, irq stays 0; set IRQ_MASK=80 → irq=1 next cycle.
- With HOST_GPIO_SETCLR_EN: DATA=0F, write OUTSET=30 → 3F, OUTCLR=03 → 3C; without macro same writes leave 0F and addr 4 reads 0.

Source files
------------

// File: rtl/host_gpio_port.sv
// Avalon-MM GPIO port: per-bit direction, synchronised inputs, sticky edge capture, maskable irq.
// Latency: readdata combinational (0 wait states); writes visible next cycle; inputs SYNC_STAGES+1 edges to EDGE_CAP/irq.
// Backpressure: none; every access completes in the cycle it is presented.
//
// Optional feature macro: HOST_GPIO_SETCLR_EN enables OUTSET (addr 4) / OUTCLR (addr 5).
// Without it those addresses behave as reserved and no set/clear logic exists.
//
// Register map (word addresses):
//   0 DATA     write: out_data; read: out_data where dir=1, synchronised input where dir=0
//   1 DIR      R/W, 1 = output (drives oe)
//   2 IRQ_MASK R/W
//   3 EDGE_CAP read captured edges, write 1 to clear
//   4 OUTSET   write 1 sets out_data bits (macro only; reads return out_data)
//   5 OUTCLR   write 1 clears out_data bits (macro only; reads return out_data)
//   6,7        reserved, read 0

module host_gpio_port #(
    parameter int          WIDTH       = 8,
    parameter logic [31:0] RESET_VALUE = 32'h0,
    parameter logic [31:0] RESET_DIR   = 32'h0,
    parameter int          EDGE_TYPE   = 0,
    parameter int          SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] out_port,
    output logic [WIDTH-1:0] oe,
    output logic             irq
);

    localparam logic [2:0] ADDR_DATA   = 3'd0;
    localparam logic [2:0] ADDR_DIR    = 3'd1;
    localparam logic [2:0] ADDR_MASK   = 3'd2;
    localparam logic [2:0] ADDR_EDGE   = 3'd3;
`ifdef HOST_GPIO_SETCLR_EN
    localparam logic [2:0] ADDR_OUTSET = 3'd4;
    localparam logic [2:0] ADDR_OUTCLR = 3'd5;
`endif

    logic [WIDTH-1:0] out_data;
    logic [WIDTH-1:0] dir;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edge_cap;

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync;
    logic [WIDTH-1:0] sync_d;
    logic [WIDTH-1:0] edge_evt;

    logic             wr_en;
    logic [WIDTH-1:0] wr_dat;
    logic [WIDTH-1:0] rd_dat;

    // Upper writedata bits are don't-care when WIDTH < 32.
    logic             unused_wdata;
    assign unused_wdata = ^writedata;

    assign wr_en  = chipselect && !write_n;
    assign wr_dat = writedata[WIDTH-1:0];

    // Input synchroniser chain; sync_d is one more stage used only for edge detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            sync_d <= '0;
        end else begin
            sync_q[0] <= in_port;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            sync_d <= sync_q[SYNC_STAGES-1];
        end
    end

    assign sync = sync_q[SYNC_STAGES-1];

    // Edge event selection; detection runs on every bit regardless of direction.
    always_comb begin
        edge_evt = '0;
        case (EDGE_TYPE)
            0:       edge_evt = sync & ~sync_d;
            1:       edge_evt = ~sync & sync_d;
            default: edge_evt = sync ^ sync_d;
        endcase
    end

    // Output data register: DATA load, plus optional atomic set/clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_data <= RESET_VALUE[WIDTH-1:0];
        end else if (wr_en) begin
            case (address)
                ADDR_DATA:   out_data <= wr_dat;
`ifdef HOST_GPIO_SETCLR_EN
                ADDR_OUTSET: out_data <= out_data | wr_dat;
                ADDR_OUTCLR: out_data <= out_data & ~wr_dat;
`endif
                default:     out_data <= out_data;
            endcase
        end
    end

    // Direction register (1 = output), drives oe directly.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dir <= RESET_DIR[WIDTH-1:0];
        end else if (wr_en && address == ADDR_DIR) begin
            dir <= wr_dat;
        end
    end

    // Interrupt mask register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_mask <= '0;
        end else if (wr_en && address == ADDR_MASK) begin
            irq_mask <= wr_dat;
        end
    end

    // Sticky edge capture; a new edge on the same cycle as its W1C keeps the bit set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edge_cap <= '0;
        end else if (wr_en && address == ADDR_EDGE) begin
            edge_cap <= (edge_cap & ~wr_dat) | edge_evt;
        end else begin
            edge_cap <= edge_cap | edge_evt;
        end
    end

    // Zero-wait-state read mux; unused upper bits read as zero.
    always_comb begin
        rd_dat = '0;
        case (address)
            ADDR_DATA: rd_dat = (dir & out_data) | (~dir & sync);
            ADDR_DIR:  rd_dat = dir;
            ADDR_MASK: rd_dat = irq_mask;
            ADDR_EDGE: rd_dat = edge_cap;
`ifdef HOST_GPIO_SETCLR_EN
            ADDR_OUTSET,
            ADDR_OUTCLR: rd_dat = out_data;
`endif
            default:   rd_dat = '0;
        endcase
        readdata = '0;
        readdata[WIDTH-1:0] = rd_dat;
    end

    assign out_port = out_data;
    assign oe       = dir;
    assign irq      = |(edge_cap & irq_mask);

endmodule

// File: tb/tb_host_gpio_port.sv
// Directed bench for host_gpio_port: register table plus edge-capture, set-wins and reset sequences.
// Two instances share the bus and pins: rising-edge (dut) and any-edge (dut_any) capture.
// Expected set/clear results follow HOST_GPIO_SETCLR_EN at compile time.

module tb_host_gpio_port;

    logic        clk;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [7:0]  in_port;

    logic [31:0] readdata;
    logic [7:0]  out_port;
    logic [7:0]  oe;
    logic        irq;

    logic [31:0] readdata_any;
    logic [7:0]  out_port_any;
    logic [7:0]  oe_any;
    logic        irq_any;

    int checks;
    int errors;

    host_gpio_port #(
        .WIDTH(8), .RESET_VALUE(32'hA5), .RESET_DIR(32'h0F), .EDGE_TYPE(0), .SYNC_STAGES(2)
    ) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata),
        .in_port(in_port), .out_port(out_port), .oe(oe), .irq(irq)
    );

    host_gpio_port #(
        .WIDTH(8), .RESET_VALUE(32'hA5), .RESET_DIR(32'h0F), .EDGE_TYPE(2), .SYNC_STAGES(2)
    ) dut_any (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata_any),
        .in_port(in_port), .out_port(out_port_any), .oe(oe_any), .irq(irq_any)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef HOST_GPIO_SETCLR_EN
    localparam logic [7:0]  EXP_SET    = 8'h3F;
    localparam logic [7:0]  EXP_CLR    = 8'h3C;
    localparam logic [31:0] EXP_RD_SET = 32'h3F;
    localparam logic [31:0] EXP_RD_CLR = 32'h3C;
`else
    localparam logic [7:0]  EXP_SET    = 8'h0F;
    localparam logic [7:0]  EXP_CLR    = 8'h0F;
    localparam logic [31:0] EXP_RD_SET = 32'h0;
    localparam logic [31:0] EXP_RD_CLR = 32'h0;
`endif

    typedef struct {
        logic        cs;
        logic        wr_n;
        logic [2:0]  addr;
        logic [31:0] wdata;
        logic [2:0]  rd_addr;
        logic [31:0] exp_rd;
        logic [7:0]  exp_out;
        logic [7:0]  exp_oe;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%08h expected=%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = a;
        writedata  = d;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd_chk(input string name, input logic [2:0] a, input logic [31:0] exp);
        address = a;
        #1;
        chk(name, readdata, exp);
    endtask

    task automatic rd_chk_any(input string name, input logic [2:0] a, input logic [31:0] exp);
        address = a;
        #1;
        chk(name, readdata_any, exp);
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        reset_n    = 1'b0;
        address    = 3'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'h0;
        in_port    = 8'h00;

        //             cs    wr_n  addr  wdata          rd    exp_rd        exp_out  exp_oe
        vecs[0]  = '{1'b0, 1'b0, 3'd0, 32'h0000_0000, 3'd0, 32'h05,       8'hA5,   8'h0F};
        vecs[1]  = '{1'b1, 1'b1, 3'd0, 32'h0000_00FF, 3'd2, 32'h00,       8'hA5,   8'h0F};
        vecs[2]  = '{1'b1, 1'b0, 3'd1, 32'h0000_00FF, 3'd1, 32'hFF,       8'hA5,   8'hFF};
        vecs[3]  = '{1'b1, 1'b0, 3'd0, 32'h0000_003C, 3'd0, 32'h3C,       8'h3C,   8'hFF};
        vecs[4]  = '{1'b1, 1'b0, 3'd2, 32'h0000_0001, 3'd2, 32'h01,       8'h3C,   8'hFF};
        vecs[5]  = '{1'b1, 1'b0, 3'd7, 32'hFFFF_FFFF, 3'd7, 32'h00,       8'h3C,   8'hFF};
        vecs[6]  = '{1'b1, 1'b0, 3'd0, 32'hFFFF_FF0F, 3'd0, 32'h0F,       8'h0F,   8'hFF};
        vecs[7]  = '{1'b1, 1'b0, 3'd4, 32'h0000_0030, 3'd4, EXP_RD_SET,   EXP_SET, 8'hFF};
        vecs[8]  = '{1'b1, 1'b0, 3'd5, 32'h0000_0003, 3'd5, EXP_RD_CLR,   EXP_CLR, 8'hFF};
        vecs[9]  = '{1'b1, 1'b0, 3'd6, 32'h0000_00FF, 3'd6, 32'h00,       EXP_CLR, 8'hFF};
        vecs[10] = '{1'b1, 1'b0, 3'd1, 32'h0000_0000, 3'd0, 32'h00,       EXP_CLR, 8'h00};
        vecs[11] = '{1'b1, 1'b0, 3'd3, 32'h0000_00FF, 3'd3, 32'h00,       EXP_CLR, 8'h00};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_port", {24'h0, out_port}, 32'hA5);
        chk("rst_oe", {24'h0, oe}, 32'h0F);
        chk("rst_irq", {31'h0, irq}, 32'h0);
        rd_chk("rst_mask", 3'd2, 32'h0);
        rd_chk("rst_edge", 3'd3, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        // Register table
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chipselect = vecs[i].cs;
            write_n    = vecs[i].wr_n;
            address    = vecs[i].addr;
            writedata  = vecs[i].wdata;
            @(posedge clk);
            #1;
            chipselect = 1'b0;
            write_n    = 1'b1;
            address    = vecs[i].rd_addr;
            #1;
            chk($sformatf("vec%0d_rd", i), readdata, vecs[i].exp_rd);
            chk($sformatf("vec%0d_out", i), {24'h0, out_port}, {24'h0, vecs[i].exp_out});
            chk($sformatf("vec%0d_oe", i), {24'h0, oe}, {24'h0, vecs[i].exp_oe});
        end

        // Rising edge on bit 0 with mask 01: irq after exactly 3 edges, W1C clears next cycle
        @(negedge clk);
        in_port[0] = 1'b1;
        tick();
        chk("edge_irq_e1", {31'h0, irq}, 32'h0);
        rd_chk("data_in_e1", 3'd0, 32'h00);
        tick();
        chk("edge_irq_e2", {31'h0, irq}, 32'h0);
        rd_chk("data_in_e2", 3'd0, 32'h01);
        tick();
        chk("edge_irq_e3", {31'h0, irq}, 32'h1);
        rd_chk("edge_cap_e3", 3'd3, 32'h01);
        bus_write(3'd3, 32'h01);
        chk("w1c_irq", {31'h0, irq}, 32'h0);
        rd_chk("w1c_cap", 3'd3, 32'h00);

        // Edge on bit 2 captured in the same cycle as its W1C: set wins
        @(negedge clk);
        in_port[2] = 1'b1;
        tick();
        tick();
        bus_write(3'd3, 32'h04);
        rd_chk("setwin_cap", 3'd3, 32'h04);
        rd_chk_any("setwin_cap_any", 3'd3, 32'h04);
        bus_write(3'd3, 32'h04);
        rd_chk("setwin_clr", 3'd3, 32'h00);

        // Falling edge on bit 7 with mask 00: only the any-edge instance captures
        @(negedge clk);
        in_port[7] = 1'b1;
        repeat (4) tick();
        bus_write(3'd3, 32'hFF);
        bus_write(3'd2, 32'h00);
        @(negedge clk);
        in_port[7] = 1'b0;
        repeat (4) tick();
        rd_chk("fall_cap_rise", 3'd3, 32'h00);
        rd_chk_any("fall_cap_any", 3'd3, 32'h80);
        chk("fall_irq_any_masked", {31'h0, irq_any}, 32'h0);
        bus_write(3'd2, 32'h80);
        chk("fall_irq_any_unmasked", {31'h0, irq_any}, 32'h1);
        chk("fall_irq_rise", {31'h0, irq}, 32'h0);

        // Asynchronous reset mid-operation, away from any clock edge
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_out_port", {24'h0, out_port}, 32'hA5);
        chk("arst_oe", {24'h0, oe}, 32'h0F);
        chk("arst_irq_any", {31'h0, irq_any}, 32'h0);
        rd_chk_any("arst_cap_any", 3'd3, 32'h00);
        rd_chk_any("arst_mask_any", 3'd2, 32'h00);

        // Inputs held high (bits 0,2) through reset release give a rising event
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        tick();
        rd_chk("post_rst_cap_e2", 3'd3, 32'h00);
        tick();
        rd_chk("post_rst_cap_e3", 3'd3, 32'h05);
        chk("post_rst_irq", {31'h0, irq}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
